// File: rtl/ascii_to_binary.sv
// ascii_to_binary: decimal ASCII field to unsigned binary, one multiply-accumulate per character.
// Define ASCII_BLANK_LEADING_EN to accept leading spaces as zeros (right-justified fields).
module ascii_to_binary #(
    parameter int BIN_WIDTH  = 13,
    parameter int BCD_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    start,
    input  logic [BCD_DIGITS*8-1:0] ascii_in,
    output logic [BIN_WIDTH-1:0]    bin,
    output logic                    ready,
    output logic                    error,
    output logic                    overflow
);
    localparam int AW = BIN_WIDTH + 4;
    localparam int IW = $clog2(BCD_DIGITS + 1);
    localparam logic [IW-1:0] LAST = IW'(BCD_DIGITS - 1);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t                  state;
    logic [BCD_DIGITS*8-1:0] sr;
    logic [AW-1:0]           acc;
    logic [IW-1:0]           idx;
    logic                    err;
    logic [7:0]              c;
    logic                    is_digit;
    logic                    blank;
    logic [AW-1:0]           acc_mac;
`ifdef ASCII_BLANK_LEADING_EN
    logic                    seen;
`endif
    always_comb begin
        c        = sr[BCD_DIGITS*8-1 -: 8];
        is_digit = (c >= 8'h30) && (c <= 8'h39);
        // for legal digits the low nibble of the character is the digit value
        acc_mac  = acc * AW'(10) + AW'(c[3:0]);
`ifdef ASCII_BLANK_LEADING_EN
        blank    = (c == 8'h20) && !seen;
`else
        blank    = 1'b0;
`endif
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sr       <= '0;
            acc      <= '0;
            idx      <= '0;
            err      <= 1'b0;
            bin      <= '0;
            ready    <= 1'b0;
            error    <= 1'b0;
            overflow <= 1'b0;
`ifdef ASCII_BLANK_LEADING_EN
            seen     <= 1'b0;
`endif
        end else if (enable) begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    // a start coinciding with the ready pulse waits one cycle
                    if (start && !ready) begin
                        sr    <= ascii_in;
                        acc   <= '0;
                        idx   <= '0;
                        err   <= 1'b0;
`ifdef ASCII_BLANK_LEADING_EN
                        seen  <= 1'b0;
`endif
                        state <= CONV;
                    end
                end
                CONV: begin
                    if (is_digit) acc <= acc_mac;
                    else if (!blank) err <= 1'b1;
`ifdef ASCII_BLANK_LEADING_EN
                    if (is_digit) seen <= 1'b1;
`endif
                    sr  <= sr << 8;
                    idx <= idx + 1'b1;
                    if (idx == LAST) state <= DONE;
                end
                DONE: begin
                    overflow <= |acc[AW-1:BIN_WIDTH];
                    bin      <= err ? '0 : acc[BIN_WIDTH-1:0];
                    error    <= err;
                    ready    <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ascii_to_binary.sv
// tb_ascii_to_binary: directed vector table plus hand-written multi-cycle sequences.
module tb_ascii_to_binary;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic [31:0] ascii_in = '0;
    logic [12:0] bin;
    logic        ready, error, overflow;
    int          n_vec = 0;
    int          n_bad = 0;

    ascii_to_binary dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .ascii_in(ascii_in),
        .bin(bin), .ready(ready), .error(error), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        int          b;
        int          e;
        int          o;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // one conversion with enable high; lat = edges from the start edge to ready
    task automatic conv(input logic [31:0] a, output int lat);
        edge1();
        ascii_in = a;
        start = 1'b1;
        edge1();
        start = 1'b0;
        lat = 0;
        while (!ready && lat < 20) begin
            edge1();
            lat++;
        end
    endtask

    vec_t vt[9];
    int   lat;
    int   pulses;

    initial begin
        vt[0] = '{"0153", 153, 0, 0};
        vt[1] = '{"8191", 8191, 0, 0};
        vt[2] = '{"9999", 1807, 0, 1};
        vt[3] = '{"12A4", 0, 1, 0};
        vt[4] = '{"0000", 0, 0, 0};
        vt[5] = '{"4008", 4008, 0, 0};
        vt[6] = '{"6 9 ", 0, 1, 0};
`ifdef ASCII_BLANK_LEADING_EN
        vt[7] = '{"  69", 69, 0, 0};
        vt[8] = '{"    ", 0, 0, 0};
`else
        vt[7] = '{"  69", 0, 1, 0};
        vt[8] = '{"    ", 0, 1, 0};
`endif
        edge1();
        edge1();
        chk("reset bin", int'(bin), 0);
        chk("reset ready", int'(ready), 0);
        chk("reset error", int'(error), 0);
        chk("reset overflow", int'(overflow), 0);
        reset = 1'b1;
        edge1();
        for (int i = 0; i < 9; i++) begin
            conv(vt[i].a, lat);
            chk($sformatf("vec%0d latency", i), lat, 5);
            chk($sformatf("vec%0d bin", i), int'(bin), vt[i].b);
            chk($sformatf("vec%0d error", i), int'(error), vt[i].e);
            chk($sformatf("vec%0d overflow", i), int'(overflow), vt[i].o);
            edge1();
            chk($sformatf("vec%0d ready drop", i), int'(ready), 0);
        end
        // stall mid-conversion, with start pulsed while busy
        edge1();
        ascii_in = "0069";
        start = 1'b1;
        edge1();
        start = 1'b0;
        lat = 0;
        edge1();
        lat++;
        enable = 1'b0;
        start = 1'b1;
        repeat (3) begin
            edge1();
            lat++;
        end
        enable = 1'b1;
        edge1();
        lat++;
        start = 1'b0;
        while (!ready && lat < 30) begin
            edge1();
            lat++;
        end
        chk("stall latency", lat, 8);
        chk("stall bin", int'(bin), 69);
        chk("stall error", int'(error), 0);
        // ready must survive a stall
        enable = 1'b0;
        edge1();
        edge1();
        chk("ready held in stall", int'(ready), 1);
        enable = 1'b1;
        edge1();
        chk("ready after stall", int'(ready), 0);
        pulses = 0;
        repeat (12) begin
            edge1();
            if (ready) pulses++;
        end
        chk("no queued start", pulses, 0);
        // start held across the ready cycle is only taken the cycle after
        conv("0153", lat);
        chk("pre latency", lat, 5);
        ascii_in = "0007";
        start = 1'b1;
        edge1();
        chk("start ignored on ready", int'(ready), 0);
        edge1();
        start = 1'b0;
        lat = 2;
        while (!ready && lat < 20) begin
            edge1();
            lat++;
        end
        chk("back-to-back latency", lat, 7);
        chk("back-to-back bin", int'(bin), 7);
        // reset mid-conversion discards everything
        edge1();
        ascii_in = "9999";
        start = 1'b1;
        edge1();
        start = 1'b0;
        edge1();
        edge1();
        reset = 1'b0;
        #1;
        chk("async reset bin", int'(bin), 0);
        chk("async reset ready", int'(ready), 0);
        chk("async reset error", int'(error), 0);
        chk("async reset overflow", int'(overflow), 0);
        edge1();
        reset = 1'b1;
        pulses = 0;
        repeat (8) begin
            edge1();
            if (ready) pulses++;
        end
        chk("no ready after reset", pulses, 0);
        conv("4008", lat);
        chk("post-reset latency", lat, 5);
        chk("post-reset bin", int'(bin), 4008);
        chk("post-reset error", int'(error), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
